spi_sample_packer: RTL

Buffer stage between the SPI sensor sampler and the host block-throttled pipe-out. Accepts 16-bit sensor results one per strobe and packs pairs into 32-bit words. Words are stored in an on-chip FIFO and presented to the pipe-out endpoint with 16-bit halves swapped, for USB2 read compatibility. Asserts a block-ready flag once a full host block is buffered, and keeps sticky error flags that are mirrored to a wire-out.

---
 rtl/spi_sample_packer.sv | 162 ++++++++++++++++
 1 files changed

// File: rtl/spi_sample_packer.sv
// Packs pairs of 16-bit sensor samples into 32-bit words, buffers them in a FIFO and
// presents them half-swapped to the pipe-out, with block-ready and sticky error flags.
module spi_sample_packer #(
    parameter int unsigned DEPTH       = 1024,
    parameter int unsigned BLOCK_WORDS = 256
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        clear,
    input  logic        sample_valid,
    input  logic [15:0] sample_data,
    input  logic        frame_start,
    input  logic        override_en,
    input  logic        fifo_read,
    output logic [31:0] fifo_dout,
    output logic        pipeout_rdy,
    output logic [12:0] word_count,
    output logic        overflow,
    output logic        underflow,
    output logic        pad_event
);

    localparam int unsigned AW       = $clog2(DEPTH);
    localparam logic [12:0] DepthCnt = 13'(DEPTH);
    localparam logic [12:0] BlockCnt = 13'(BLOCK_WORDS);
    localparam logic [12:0] CntOne   = 13'd1;
    localparam logic [AW-1:0] PtrOne = AW'(1);

    logic          flush;

    logic [15:0]   held_q, held_d;
    logic          half_pending_q, half_pending_d;
    logic          push;
    logic [31:0]   push_word;
    logic          pad_set;

    logic [31:0]   mem_q [DEPTH];
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [12:0]   count_q, count_d;
    logic [31:0]   dout_q, dout_d;
    logic          overflow_q, overflow_d;
    logic          underflow_q, underflow_d;
    logic          pad_event_q, pad_event_d;

    logic          fifo_empty;
    logic          fifo_full;
    logic          pop_ok;
    logic          push_ok;
    logic [31:0]   rd_word;

    assign flush = ~reset_n | clear;

    // Pack register: a frame_start with a half pending flushes the held half zero-padded.
    always_comb begin
        held_d         = held_q;
        half_pending_d = half_pending_q;
        push           = 1'b0;
        push_word      = 32'h0;
        pad_set        = 1'b0;
        if (sample_valid) begin
            if (half_pending_q) begin
                push = 1'b1;
                if (frame_start) begin
                    push_word = {16'h0000, held_q};
                    pad_set   = 1'b1;
                    held_d    = sample_data;
                end else begin
                    push_word      = {sample_data, held_q};
                    half_pending_d = 1'b0;
                end
            end else begin
                held_d         = sample_data;
                half_pending_d = 1'b1;
            end
        end
        if (flush) begin
            held_d         = 16'h0;
            half_pending_d = 1'b0;
        end
    end

    assign fifo_empty = (count_q == 13'd0);
    assign fifo_full  = (count_q == DepthCnt);
    assign rd_word    = mem_q[rd_ptr_q];

    // A pop in the same cycle frees the slot, so a push into a full FIFO still lands.
    assign pop_ok  = fifo_read & ~fifo_empty & ~flush;
    assign push_ok = push & (~fifo_full | pop_ok) & ~flush;

    always_comb begin
        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        count_d     = count_q;
        dout_d      = dout_q;
        overflow_d  = overflow_q | (push & ~push_ok);
        underflow_d = underflow_q | (fifo_read & fifo_empty);
        pad_event_d = pad_event_q | pad_set;

        if (push_ok) begin
            wr_ptr_d = wr_ptr_q + PtrOne;
        end
        if (pop_ok) begin
            rd_ptr_d = rd_ptr_q + PtrOne;
            dout_d   = {rd_word[15:0], rd_word[31:16]};
        end
        case ({push_ok, pop_ok})
            2'b10:   count_d = count_q + CntOne;
            2'b01:   count_d = count_q - CntOne;
            default: count_d = count_q;
        endcase

        if (flush) begin
            wr_ptr_d    = '0;
            rd_ptr_d    = '0;
            count_d     = 13'd0;
            dout_d      = 32'h0;
            overflow_d  = 1'b0;
            underflow_d = 1'b0;
            pad_event_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            held_q         <= 16'h0;
            half_pending_q <= 1'b0;
            wr_ptr_q       <= '0;
            rd_ptr_q       <= '0;
            count_q        <= 13'd0;
            dout_q         <= 32'h0;
            overflow_q     <= 1'b0;
            underflow_q    <= 1'b0;
            pad_event_q    <= 1'b0;
        end else begin
            held_q         <= held_d;
            half_pending_q <= half_pending_d;
            wr_ptr_q       <= wr_ptr_d;
            rd_ptr_q       <= rd_ptr_d;
            count_q        <= count_d;
            dout_q         <= dout_d;
            overflow_q     <= overflow_d;
            underflow_q    <= underflow_d;
            pad_event_q    <= pad_event_d;
        end
    end

    // Storage array carries no reset; contents are only visible through valid pointers.
    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem_q[wr_ptr_q] <= push_word;
        end
    end

    assign fifo_dout   = dout_q;
    assign word_count  = count_q;
    assign pipeout_rdy = (count_q >= BlockCnt) | override_en;
    assign overflow    = overflow_q;
    assign underflow   = underflow_q;
    assign pad_event   = pad_event_q;

endmodule
